hashing_clock_governor: RTL and testbench
=========================================

Name: hashing_clock_governor

Overview:
Run-time controller for the hashing clock PLL, replacing fixed multiply/divide with a frequency that can change while running.
- Ramps the PLL multiplier toward a host-requested target in bounded steps, driving a PLL reconfiguration engine over a valid/ready handshake.
- Confirms lock after each step and reverts to the last good setting on lock failure.
- Optionally throttles the target down when the hashing cores report errors.
- Sits between the host/comm logic and the PLL reconfig engine, in the rx_clk domain.

Parameters:
INPUT_FREQUENCY, 50, reference clock in MHz (reporting only)
DIVIDE_BY, 1, fixed PLL divide value sent with every config
MULT_WIDTH, 8, width of multiplier fields
MULT_MIN, 2, lowest legal multiplier
MULT_MAX, 8, highest legal multiplier
MULT_INIT, 4, multiplier the PLL powers up with
STEP, 1, maximum multiplier change per reconfig
LOCK_TIMEOUT, 65536, cycles allowed from config transfer to lock
DWELL_CYCLES, 1024, cycles held at each new setting before the next step
ERROR_THRESHOLD, 4, errors per window that trigger a throttle
WINDOW_CYCLES, 1048576, error-count window length

Ports:
rx_clk  in  1  controller clock
rx_reset_n  in  1  reset, asynchronous assert, active-low
rx_target_valid  in  1  single-cycle strobe: load new target
rx_target_mult  in  MULT_WIDTH  requested multiplier
rx_fault_clear  in  1  clears tx_fault
rx_pll_locked  in  1  PLL lock; asynchronous, synchronised internally
rx_hash_error  in  1  single-cycle error pulse from the hashing cores
rx_cfg_ready  in  1  reconfig engine idle and able to accept a config
tx_cfg_valid  out  1  config request
tx_cfg_multiply  out  MULT_WIDTH  multiplier to program
tx_cfg_divide  out  MULT_WIDTH  divide value to program (= DIVIDE_BY)
tx_current_mult  out  MULT_WIDTH  last successfully locked multiplier
tx_target_mult  out  MULT_WIDTH  current clamped target
tx_busy  out  1  high whenever state is not IDLE
tx_fault  out  1  sticky: lock failure occurred

Behaviour:
- Reset values:
  - tx_cfg_valid=0.
  - tx_cfg_multiply, tx_current_mult, tx_target_mult and last_good all = MULT_INIT.
  - tx_cfg_divide=DIVIDE_BY; tx_fault=0.
  - Internal counters = 0.
  - State=WAIT_LOCK; the power-up PLL lock is confirmed first.
- rx_pll_locked passes through a 2-flop synchroniser; all decisions below use the synchronised value.
- Target load: on rx_target_valid, the target is clamped to [MULT_MIN, MULT_MAX] and loaded in any state. It takes effect at the next IDLE decision. An in-flight config is never aborted.
- States:
  - IDLE:
    - If synced lock is low, go to WAIT_LOCK.
    - Else if current != target: next = current ± min(STEP, |target-current|); drive tx_cfg_multiply=next and tx_cfg_valid=1; go to ISSUE.
    - Else stay.
  - ISSUE:
    - tx_cfg_valid and payload are held stable until a cycle with rx_cfg_ready=1; that cycle is the transfer.
    - On transfer, deassert valid the next cycle, clear the timer, go to WAIT_LOCK.
  - WAIT_LOCK:
    - The first 4 cycles are blanking; lock is ignored.
    - Then synced lock high → tx_current_mult=last_good=tx_cfg_multiply, go to DWELL.
    - If the timer reaches LOCK_TIMEOUT → FAULT.
  - DWELL:
    - Count DWELL_CYCLES, then go to IDLE.
    - Synced lock low during DWELL → WAIT_LOCK (timer restarts, no reconfig).
  - FAULT (1 cycle):
    - Set tx_fault.
    - If tx_cfg_multiply != last_good, target=next=last_good.
    - Otherwise (the fallback itself failed), target=next=MULT_MIN.
    - Go to ISSUE with the new config.
- tx_fault stays set until an rx_fault_clear pulse. A simultaneous set and clear leaves it set.
- Multiplier arithmetic is unsigned at MULT_WIDTH. STEP never overshoots the target, and next is always within [MULT_MIN, MULT_MAX].

Optional Feature:
Macro: HASHING_CLOCK_GOVERNOR_THROTTLE_EN.
- Defined:
  - The error counter increments on rx_hash_error and clears every WINDOW_CYCLES.
  - When it reaches ERROR_THRESHOLD, target = max(target-STEP, MULT_MIN), the counter clears and the window restarts.
  - If rx_target_valid arrives in the same cycle as a throttle, the host value wins and the counter clears.
- Undefined: rx_hash_error is ignored and no counter or window logic is built.

Test Plan:
- Reset with MULT_INIT=4, assert lock after 10 cycles → tx_busy falls after blanking + lock + DWELL; tx_current_mult=4, tx_cfg_valid never asserted.
- Target 7, STEP=1, rx_cfg_ready always 1 → three transfers carrying 5, 6, 7, each separated by lock + DWELL; tx_current_mult ends at 7.
- Target 7 with rx_cfg_ready held 0 for 20 cycles → tx_cfg_valid=1 with tx_cfg_multiply=5 held stable for 20 cycles; exactly one transfer.
- Step to 5 with lock held low → after LOCK_TIMEOUT: tx_fault=1, config 4 reissued, tx_target_mult=4. Then rx_fault_clear → tx_fault=0.
- Target 20 → tx_target_mult=8. Target 0 → tx_target_mult=2.
- With HASHING_CLOCK_GOVERNOR_THROTTLE_EN, settled at 7: 4 error pulses inside one window → target 6, one config with multiply=6. Three errors per window repeatedly → no change.

Source files
------------

// File: rtl/hashing_clock_governor.sv
// ============================================================================
// hashing_clock_governor: ramps the hashing PLL multiplier to a host target
// with lock confirmation and fallback. Optional: HASHING_CLOCK_GOVERNOR_THROTTLE_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module hashing_clock_governor #(
  parameter int INPUT_FREQUENCY = 50,
  parameter int DIVIDE_BY       = 1,
  parameter int MULT_WIDTH      = 8,
  parameter int MULT_MIN        = 2,
  parameter int MULT_MAX        = 8,
  parameter int MULT_INIT       = 4,
  parameter int STEP            = 1,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int DWELL_CYCLES    = 1024,
  parameter int ERROR_THRESHOLD = 4,
  parameter int WINDOW_CYCLES   = 1048576
) (
  input  logic                  rx_clk,
  input  logic                  rx_reset_n,
  input  logic                  rx_target_valid,
  input  logic [MULT_WIDTH-1:0] rx_target_mult,
  input  logic                  rx_fault_clear,
  input  logic                  rx_pll_locked,
  input  logic                  rx_hash_error,
  input  logic                  rx_cfg_ready,
  output logic                  tx_cfg_valid,
  output logic [MULT_WIDTH-1:0] tx_cfg_multiply,
  output logic [MULT_WIDTH-1:0] tx_cfg_divide,
  output logic [MULT_WIDTH-1:0] tx_current_mult,
  output logic [MULT_WIDTH-1:0] tx_target_mult,
  output logic                  tx_busy,
  output logic                  tx_fault
);

  localparam int BLANK_CYCLES = 4;
  localparam int TIMER_MAX_A  = (LOCK_TIMEOUT > DWELL_CYCLES) ? LOCK_TIMEOUT : DWELL_CYCLES;
  localparam int TIMER_MAX    = (TIMER_MAX_A > BLANK_CYCLES) ? TIMER_MAX_A : BLANK_CYCLES;
  localparam int TIMER_W      = $clog2(TIMER_MAX + 1);

  localparam logic [MULT_WIDTH-1:0] MIN_M  = MULT_WIDTH'(MULT_MIN);
  localparam logic [MULT_WIDTH-1:0] MAX_M  = MULT_WIDTH'(MULT_MAX);
  localparam logic [MULT_WIDTH-1:0] INIT_M = MULT_WIDTH'(MULT_INIT);
  localparam logic [MULT_WIDTH-1:0] STEP_M = MULT_WIDTH'(STEP);
  localparam logic [MULT_WIDTH-1:0] DIV_M  = MULT_WIDTH'(DIVIDE_BY);

  localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(LOCK_TIMEOUT);
  localparam logic [TIMER_W-1:0] DWELL_T   = TIMER_W'(DWELL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BLANK_T   = TIMER_W'(BLANK_CYCLES);

  generate
    if (INPUT_FREQUENCY <= 0 || STEP <= 0 || MULT_MIN > MULT_INIT || MULT_INIT > MULT_MAX ||
        LOCK_TIMEOUT <= BLANK_CYCLES || DWELL_CYCLES <= 0 || ERROR_THRESHOLD <= 0 ||
        WINDOW_CYCLES <= 1) begin : g_param_check
      $error("hashing_clock_governor: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_DWELL     = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  function automatic logic [MULT_WIDTH-1:0] clamp_mult(input logic [MULT_WIDTH-1:0] m);
    if (m < MIN_M)      clamp_mult = MIN_M;
    else if (m > MAX_M) clamp_mult = MAX_M;
    else                clamp_mult = m;
  endfunction

  state_t                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  lock_meta_q, lock_sync_q;
  logic                  cfg_valid_q, cfg_valid_d;
  logic [MULT_WIDTH-1:0] cfg_mult_q, cfg_mult_d;
  logic [MULT_WIDTH-1:0] cur_q, cur_d;
  logic [MULT_WIDTH-1:0] last_good_q, last_good_d;
  logic [MULT_WIDTH-1:0] tgt_q, tgt_d;
  logic                  fault_q, fault_d;

  logic                  throttle_hit;
  logic [MULT_WIDTH-1:0] throttle_tgt;

`ifdef HASHING_CLOCK_GOVERNOR_THROTTLE_EN
  localparam int ERR_W = $clog2(ERROR_THRESHOLD + 1);
  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);

  logic [ERR_W-1:0] err_cnt_q, err_cnt_d, err_sum;
  logic [WIN_W-1:0] win_q, win_d;

  always_comb begin
    err_sum      = err_cnt_q + ERR_W'(rx_hash_error);
    throttle_hit = (err_sum >= ERR_W'(ERROR_THRESHOLD));
    throttle_tgt = ((tgt_q - MIN_M) <= STEP_M) ? MIN_M : (tgt_q - STEP_M);
    err_cnt_d    = err_sum;
    win_d        = win_q + WIN_W'(1);
    // A throttle restarts the window so the next decision sees a fresh count.
    if (throttle_hit || win_q == WIN_W'(WINDOW_CYCLES - 1)) begin
      err_cnt_d = '0;
      win_d     = '0;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      err_cnt_q <= '0;
      win_q     <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      win_q     <= win_d;
    end
  end
`else
  logic unused_hash_error;
  assign unused_hash_error = rx_hash_error;
  assign throttle_hit      = 1'b0;
  assign throttle_tgt      = tgt_q;
`endif

  // Next setting: one bounded step from current toward target, never past it.
  logic [MULT_WIDTH-1:0] diff, step_amt, next_mult;
  always_comb begin
    if (tgt_q > cur_q) diff = tgt_q - cur_q;
    else               diff = cur_q - tgt_q;
    step_amt = (diff < STEP_M) ? diff : STEP_M;
    if (tgt_q > cur_q) next_mult = clamp_mult(cur_q + step_amt);
    else               next_mult = clamp_mult(cur_q - step_amt);
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cfg_valid_d = cfg_valid_q;
    cfg_mult_d  = cfg_mult_q;
    cur_d       = cur_q;
    last_good_d = last_good_q;
    tgt_d       = tgt_q;
    fault_d     = rx_fault_clear ? 1'b0 : fault_q;

    if (throttle_hit) tgt_d = throttle_tgt;

    case (state_q)
      ST_IDLE: begin
        if (!lock_sync_q) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (cur_q != tgt_q) begin
          cfg_mult_d  = next_mult;
          cfg_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rx_cfg_ready) begin
          cfg_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (timer_q >= BLANK_T && lock_sync_q) begin
          cur_d       = cfg_mult_q;
          last_good_d = cfg_mult_q;
          timer_d     = '0;
          state_d     = ST_DWELL;
        end else if (timer_q >= TIMEOUT_T) begin
          timer_d = '0;
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_DWELL: begin
        if (!lock_sync_q) begin
          timer_d = '0;
          state_d = ST_WAIT_LOCK;
        end else if (timer_q >= DWELL_T) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_FAULT: begin
        // A failed fallback means last_good itself is suspect; drop to the floor.
        fault_d     = 1'b1;
        cfg_mult_d  = (cfg_mult_q != last_good_q) ? last_good_q : MIN_M;
        tgt_d       = cfg_mult_d;
        cfg_valid_d = 1'b1;
        state_d     = ST_ISSUE;
      end
      default: begin
        timer_d = '0;
        state_d = ST_WAIT_LOCK;
      end
    endcase

    if (rx_target_valid) tgt_d = clamp_mult(rx_target_mult);
  end

  always_ff @(posedge rx_clk or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      state_q     <= ST_WAIT_LOCK;
      timer_q     <= '0;
      cfg_valid_q <= 1'b0;
      cfg_mult_q  <= INIT_M;
      cur_q       <= INIT_M;
      last_good_q <= INIT_M;
      tgt_q       <= INIT_M;
      fault_q     <= 1'b0;
    end else begin
      lock_meta_q <= rx_pll_locked;
      lock_sync_q <= lock_meta_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_mult_q  <= cfg_mult_d;
      cur_q       <= cur_d;
      last_good_q <= last_good_d;
      tgt_q       <= tgt_d;
      fault_q     <= fault_d;
    end
  end

  assign tx_cfg_valid    = cfg_valid_q;
  assign tx_cfg_multiply = cfg_mult_q;
  assign tx_cfg_divide   = DIV_M;
  assign tx_current_mult = cur_q;
  assign tx_target_mult  = tgt_q;
  assign tx_busy         = (state_q != ST_IDLE);
  assign tx_fault        = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_hashing_clock_governor.sv
// ============================================================================
// tb_hashing_clock_governor: directed self-checking bench for the PLL governor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hashing_clock_governor;

  localparam int MW  = 8;
  localparam int WIN = 200;

  logic          rx_clk = 1'b0;
  logic          rx_reset_n = 1'b0;
  logic          rx_target_valid = 1'b0;
  logic [MW-1:0] rx_target_mult = '0;
  logic          rx_fault_clear = 1'b0;
  logic          rx_pll_locked = 1'b0;
  logic          rx_hash_error = 1'b0;
  logic          rx_cfg_ready = 1'b0;
  logic          tx_cfg_valid;
  logic [MW-1:0] tx_cfg_multiply;
  logic [MW-1:0] tx_cfg_divide;
  logic [MW-1:0] tx_current_mult;
  logic [MW-1:0] tx_target_mult;
  logic          tx_busy;
  logic          tx_fault;

  hashing_clock_governor #(
    .MULT_WIDTH   (MW),
    .LOCK_TIMEOUT (64),
    .DWELL_CYCLES (16),
    .WINDOW_CYCLES(WIN)
  ) dut (
    .rx_clk          (rx_clk),
    .rx_reset_n      (rx_reset_n),
    .rx_target_valid (rx_target_valid),
    .rx_target_mult  (rx_target_mult),
    .rx_fault_clear  (rx_fault_clear),
    .rx_pll_locked   (rx_pll_locked),
    .rx_hash_error   (rx_hash_error),
    .rx_cfg_ready    (rx_cfg_ready),
    .tx_cfg_valid    (tx_cfg_valid),
    .tx_cfg_multiply (tx_cfg_multiply),
    .tx_cfg_divide   (tx_cfg_divide),
    .tx_current_mult (tx_current_mult),
    .tx_target_mult  (tx_target_mult),
    .tx_busy         (tx_busy),
    .tx_fault        (tx_fault)
  );

  always #5 rx_clk = ~rx_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit seen_valid = 1'b0;
  logic [MW-1:0] xfer_mult[$];

  always @(posedge rx_clk) begin
    if (rx_reset_n) begin
      cyc = cyc + 1;
      if (tx_cfg_valid) seen_valid = 1'b1;
      if (tx_cfg_valid && rx_cfg_ready) xfer_mult.push_back(tx_cfg_multiply);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  task automatic load_target(input logic [MW-1:0] v);
    rx_target_valid = 1'b1;
    rx_target_mult  = v;
    tick(1);
    rx_target_valid = 1'b0;
  endtask

  task automatic wait_settled(input string tag, input logic [MW-1:0] exp, input int budget);
    int k = 0;
    while (!(tx_current_mult === exp && tx_busy === 1'b0) && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  initial begin
    int held;
    int k;
    int n0;

    // Reset values
    tick(3);
    check("rst_busy",    32'(tx_busy), 32'd1);
    check("rst_valid",   32'(tx_cfg_valid), 32'd0);
    check("rst_cfg_mul", 32'(tx_cfg_multiply), 32'd4);
    check("rst_current", 32'(tx_current_mult), 32'd4);
    check("rst_target",  32'(tx_target_mult), 32'd4);
    check("rst_divide",  32'(tx_cfg_divide), 32'd1);
    check("rst_fault",   32'(tx_fault), 32'd0);

    // Power-up lock confirmation
    rx_reset_n = 1'b1;
    tick(10);
    rx_pll_locked = 1'b1;
    k = 0;
    while (tx_busy !== 1'b0 && k < 100) begin
      tick(1);
      k++;
    end
    check("boot_settle", 32'(k < 100), 32'd1);
    check("boot_current", 32'(tx_current_mult), 32'd4);
    check("boot_no_valid", 32'(seen_valid), 32'd0);

    // Target 7 with the reconfig engine stalled for 20 cycles
    rx_cfg_ready = 1'b0;
    load_target(8'd7);
    check("tgt7_loaded", 32'(tx_target_mult), 32'd7);
    tick(1);
    held = 0;
    repeat (20) begin
      if (tx_cfg_valid === 1'b1 && tx_cfg_multiply === 8'd5) held++;
      tick(1);
    end
    check("stall_hold_cycles", 32'(held), 32'd20);
    check("stall_no_xfer", 32'(xfer_mult.size()), 32'd0);
    rx_cfg_ready = 1'b1;
    wait_settled("ramp7_settle", 8'd7, 300);
    check("ramp7_xfers", 32'(xfer_mult.size()), 32'd3);
    if (xfer_mult.size() == 3) begin
      check("ramp7_x0", 32'(xfer_mult[0]), 32'd5);
      check("ramp7_x1", 32'(xfer_mult[1]), 32'd6);
      check("ramp7_x2", 32'(xfer_mult[2]), 32'd7);
    end
    check("ramp7_current", 32'(tx_current_mult), 32'd7);
    check("ramp7_valid_low", 32'(tx_cfg_valid), 32'd0);

    // Step to 6, lock lost after transfer -> timeout, fallback to 7
    load_target(8'd6);
    k = 0;
    while (xfer_mult.size() < 4 && k < 20) begin
      tick(1);
      k++;
    end
    rx_pll_locked = 1'b0;
    check("step6_xfer", 32'(k < 20), 32'd1);
    k = 0;
    while (tx_fault !== 1'b1 && k < 200) begin
      tick(1);
      k++;
    end
    check("fault_raised", 32'(k < 200), 32'd1);
    check("fault_target", 32'(tx_target_mult), 32'd7);
    check("fault_cfg_mul", 32'(tx_cfg_multiply), 32'd7);
    check("fault_cfg_valid", 32'(tx_cfg_valid), 32'd1);
    check("fault_current", 32'(tx_current_mult), 32'd7);
    rx_pll_locked = 1'b1;
    wait_settled("fallback_settle", 8'd7, 200);
    check("fallback_xfers", 32'(xfer_mult.size()), 32'd5);
    if (xfer_mult.size() == 5) check("fallback_mul", 32'(xfer_mult[4]), 32'd7);
    check("fault_sticky", 32'(tx_fault), 32'd1);
    rx_fault_clear = 1'b1;
    tick(1);
    rx_fault_clear = 1'b0;
    check("fault_cleared", 32'(tx_fault), 32'd0);

    // Target clamping at both ends
    load_target(8'd20);
    check("clamp_high", 32'(tx_target_mult), 32'd8);
    load_target(8'd0);
    check("clamp_low", 32'(tx_target_mult), 32'd2);
    wait_settled("down_settle", 8'd2, 400);
    check("down_current", 32'(tx_current_mult), 32'd2);
    check("down_xfers", 32'(xfer_mult.size()), 32'd12);
    if (xfer_mult.size() == 12) begin
      check("down_first", 32'(xfer_mult[5]), 32'd8);
      check("down_last", 32'(xfer_mult[11]), 32'd2);
    end

`ifdef HASHING_CLOCK_GOVERNOR_THROTTLE_EN
    load_target(8'd7);
    wait_settled("thr_ramp_settle", 8'd7, 400);
    n0 = xfer_mult.size();
    k = 0;
    while ((cyc % WIN) > 100 && k < WIN) begin
      tick(1);
      k++;
    end
    repeat (4) begin
      rx_hash_error = 1'b1;
      tick(1);
      rx_hash_error = 1'b0;
      tick(3);
    end
    check("thr_target", 32'(tx_target_mult), 32'd6);
    wait_settled("thr_settle", 8'd6, 200);
    check("thr_xfers", 32'(xfer_mult.size()), 32'(n0 + 1));
    if (xfer_mult.size() == n0 + 1) check("thr_mul", 32'(xfer_mult[n0]), 32'd6);
    repeat (3) begin
      repeat (3) begin
        rx_hash_error = 1'b1;
        tick(1);
        rx_hash_error = 1'b0;
        tick(3);
      end
      tick(250);
    end
    check("thr3_target", 32'(tx_target_mult), 32'd6);
    check("thr3_xfers", 32'(xfer_mult.size()), 32'(n0 + 1));
    check("thr3_current", 32'(tx_current_mult), 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
